proc_sequencer: RTL and testbench
=================================

PROC_SEQUENCER -- requirements
Module: proc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 6: program-memory address width.
REQ-002 Parameter TIMEOUT, default 15: maximum WAIT cycles before the fault state.
REQ-003 Parameter HALT_OP, default 3'b111: opcode that stops sequencing.
REQ-004 Clock  in  1: single clock; all state updates on the rising edge.
REQ-005 Reset  in  1: synchronous, active-high.
REQ-006 Start  in  1: begin execution at the current PC.
REQ-007 Stop  in  1: finish the in-flight instruction, then go idle.
REQ-008 MemAddr  out  ADDR_W: program-memory read address.
REQ-009 MemData  in  9: program word; synchronous read, valid the cycle after MemAddr is presented.
REQ-010 ProcDIN  out  9: drives the processor DIN input.
REQ-011 ProcRun  out  1: drives the processor Run input.
REQ-012 ProcDone  in  1: processor Done output.
REQ-013 PC  out  ADDR_W: program counter.
REQ-014 Busy, Halted, Error  out  1 each: status flags.
REQ-015 InstrCount  out  8: count of retired instructions.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, LOAD, ISSUE, IMM, WAIT, HALT and ERROR.
REQ-017 Outputs SHALL be state-decoded; the only input-to-output combinational paths SHALL be MemData->ProcDIN in LOAD and IMM.
REQ-018 IDLE: Busy=0 and ProcRun=0; Start=1 with Stop=0 -> FETCH; Start and Stop both 1 -> stay IDLE.
REQ-019 FETCH: MemAddr=PC, ProcRun=0; next state LOAD.
REQ-020 LOAD: ProcDIN=MemData, ProcRun=0, MemData captured into an internal instruction register (so the processor loads IR); opcode MemData[8:6]==HALT_OP -> HALT; otherwise -> ISSUE.
REQ-021 ISSUE: ProcDIN=instruction register, ProcRun=1 for exactly one cycle, MemAddr=PC+1 (mod 2^ADDR_W); opcode 3'b001 (MVI) -> IMM; otherwise -> WAIT.
REQ-022 IMM: ProcDIN=MemData (the immediate word), ProcRun=0; next state WAIT.
REQ-023 WAIT: ProcRun=0, ProcDIN=0; a wait counter SHALL clear on entry and increment each WAIT cycle.
REQ-024 WAIT with ProcDone=1 SHALL retire the instruction: PC advances by 2 for MVI and by 1 otherwise, modulo 2^ADDR_W, and InstrCount increments, wrapping from 255 to 0.
REQ-025 After retire: Stop latched -> IDLE, with the Stop latch cleared; otherwise -> FETCH.
REQ-026 WAIT with ProcDone=0 and the wait counter equal to TIMEOUT SHALL go to ERROR.
REQ-027 Expected retire timing: MV/MVI in the first WAIT cycle; ADD/SUB in the third WAIT cycle.
REQ-028 Stop=1 in any state other than IDLE, HALT or ERROR SHALL set a sticky latch, honoured only at retire; the instruction is never aborted.
REQ-029 Start while Busy=1 SHALL be ignored.
REQ-030 HALT: Halted=1, Busy=0, ProcRun=0, PC frozen at the HALT word address, no exit except Reset.
REQ-031 ERROR: Error=1, Busy=0, ProcRun=0, PC frozen, no exit except Reset.
REQ-032 Busy SHALL equal 1 in FETCH, LOAD, ISSUE, IMM and WAIT.
REQ-033 PC wrap: an MVI at address 2^ADDR_W-1 SHALL take its immediate from address 0 and retire with PC=1.

Reset
REQ-034 Reset=1 on a clock edge SHALL force IDLE from any state, including mid-instruction, and clear the Stop latch and the wait counter.
REQ-035 Reset values: PC=0, InstrCount=0, MemAddr=0, ProcDIN=0, ProcRun=0, Busy=0, Halted=0, Error=0.
REQ-036 Reset SHALL take priority over Start, Stop and ProcDone.

Verification
REQ-037 Memory {0:MVI R0 (9'b001000000), 1:9'h005, 2:HALT 9'b111000000}, Start pulse -> ProcRun high one cycle, ProcDIN=9'h005 in IMM, then Halted=1, PC=2, InstrCount=1.
REQ-038 ADD R1,R2 at address 0 with ProcDone low for 2 WAIT cycles, high on the 3rd -> retire in WAIT cycle 3, PC=1, InstrCount=1, next state FETCH.
REQ-039 ProcDone held 0 in WAIT -> Error=1 after TIMEOUT=15 WAIT cycles, ProcRun stays 0, PC unchanged.
REQ-040 Stop pulsed during ISSUE of an MV at PC=4 -> the MV retires, PC=5, state IDLE, Busy=0; a later Start resumes with a fetch at 5.
REQ-041 PC preset to 63 (ADDR_W=6) with an MVI at 63 -> MemAddr=0 in ISSUE, retire PC=1.
REQ-042 Reset asserted in WAIT of an ADD -> the next cycle has all outputs at their reset values, IDLE, and no retire counted.

Source files
------------

// File: rtl/proc_sequencer_if.sv
// Bus bundle between the sequencer, its program memory and the processor it feeds.
// The master modport is the sequencer side; slave is the environment.
interface proc_sequencer_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic              stop;
    logic [ADDR_W-1:0] mem_addr;
    logic [8:0]        mem_data;
    logic [8:0]        proc_din;
    logic              proc_run;
    logic              proc_done;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              halted;
    logic              error;
    logic [7:0]        instr_count;

    modport master (
        input  start, stop, mem_data, proc_done,
        output mem_addr, proc_din, proc_run, pc, busy, halted, error, instr_count
    );

    modport slave (
        output start, stop, mem_data, proc_done,
        input  mem_addr, proc_din, proc_run, pc, busy, halted, error, instr_count
    );
endinterface

// File: rtl/proc_sequencer.sv
// Fetches 9-bit program words from a synchronous memory and feeds them to a
// simple processor one instruction at a time, waiting on Done with a timeout.
module proc_sequencer #(
    parameter int          ADDR_W  = 6,
    parameter int          TIMEOUT = 15,
    parameter logic [2:0]  HALT_OP = 3'b111
) (
    input  logic             clk,
    input  logic             rst,
    proc_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, ISSUE, IMM, WAIT, HALT, ERROR} state_t;

    localparam logic [2:0] MVI_OP = 3'b001;
    localparam int         WCW    = $clog2(TIMEOUT + 1);

    state_t            state;
    logic [8:0]        ir;
    logic [WCW-1:0]    wait_cnt;
    logic              stop_q;
    logic [ADDR_W-1:0] pc_ret;

    // MVI occupies two words (opcode + immediate), everything else one.
    assign pc_ret = bus.pc + ((ir[8:6] == MVI_OP) ? ADDR_W'(2) : ADDR_W'(1));

    // Memory data is forwarded combinationally while the processor loads IR
    // and the immediate; the issued word comes from the captured IR.
    always_comb begin
        bus.proc_din = 9'd0;
        if (state == LOAD || state == IMM) bus.proc_din = bus.mem_data;
        else if (state == ISSUE)           bus.proc_din = ir;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            ir              <= 9'd0;
            wait_cnt        <= '0;
            stop_q          <= 1'b0;
            bus.pc          <= '0;
            bus.instr_count <= 8'd0;
            bus.mem_addr    <= '0;
            bus.proc_run    <= 1'b0;
            bus.busy        <= 1'b0;
            bus.halted      <= 1'b0;
            bus.error       <= 1'b0;
        end else begin
            bus.proc_run <= 1'b0;
            if (bus.stop && state != IDLE && state != HALT && state != ERROR)
                stop_q <= 1'b1;

            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state        <= FETCH;
                        bus.busy     <= 1'b1;
                        bus.mem_addr <= bus.pc;
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    ir <= bus.mem_data;
                    if (bus.mem_data[8:6] == HALT_OP) begin
                        state      <= HALT;
                        bus.busy   <= 1'b0;
                        bus.halted <= 1'b1;
                    end else begin
                        state        <= ISSUE;
                        bus.proc_run <= 1'b1;
                        bus.mem_addr <= bus.pc + ADDR_W'(1);
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= (ir[8:6] == MVI_OP) ? IMM : WAIT;
                end
                IMM: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (bus.proc_done) begin
                        bus.pc          <= pc_ret;
                        bus.mem_addr    <= pc_ret;
                        bus.instr_count <= bus.instr_count + 8'd1;
                        if (stop_q || bus.stop) begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                            stop_q   <= 1'b0;
                        end else begin
                            state <= FETCH;
                        end
                    end else if (wait_cnt + WCW'(1) == WCW'(TIMEOUT)) begin
                        state     <= ERROR;
                        bus.busy  <= 1'b0;
                        bus.error <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                HALT:    state <= HALT;
                ERROR:   state <= ERROR;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_proc_sequencer.sv
// Directed and randomized checks of proc_sequencer against a program-level
// model of the memory and a Done-latency model of the processor.
module tb_proc_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    proc_sequencer_if #(.ADDR_W(6)) bus();

    proc_sequencer #(.ADDR_W(6), .TIMEOUT(15), .HALT_OP(3'b111)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    localparam logic [8:0] W_HALT = 9'b111_000_000;
    localparam logic [8:0] W_ADD  = 9'b010_001_010;

    logic [8:0] mem [64];
    always @(posedge clk) bus.mem_data <= mem[bus.mem_addr];

    int npass = 0, ntot = 0;
    int pend, k, tgt, runs, ii;
    logic [2:0] op;
    bit hold, chk_en;
    logic [8:0] exp_ins [64];
    logic [8:0] exp_imm [64];
    logic [5:0] exp_pc  [64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One cycle; processor model drives Done on the WAIT cycle matching its latency.
    task automatic tick();
        logic [5:0] nxt;
        @(negedge clk);
        if (rst) begin
            pend = 0;
            bus.proc_done = 1'b0;
        end else if (bus.proc_run) begin
            pend = 1; k = 0; op = bus.proc_din[8:6]; runs++;
            bus.proc_done = 1'b0;
            case (op)
                3'd0, 3'd1: tgt = 1;
                3'd2, 3'd3: tgt = 3;
                default:    tgt = $urandom_range(1, 8);
            endcase
            if (chk_en && ii < 64) begin
                nxt = exp_pc[ii] + 6'd1;
                chk("issue_din", bus.proc_din, exp_ins[ii]);
                chk("issue_addr", bus.mem_addr, nxt);
                ii++;
            end
        end else if (pend != 0) begin
            k++;
            if (chk_en && op == 3'b001 && k == 1 && ii > 0)
                chk("imm_din", bus.proc_din, exp_imm[ii-1]);
            bus.proc_done = !hold && (k == tgt + ((op == 3'b001) ? 1 : 0));
            if (bus.proc_done) pend = 0;
        end else begin
            bus.proc_done = 1'b0;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = W_HALT;
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.start = 1'b0; bus.stop = 1'b0; hold = 0;
        repeat (2) tick();
        rst = 1'b0; runs = 0; ii = 0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_pc"},       bus.pc, 0);
        chk({p, "_count"},    bus.instr_count, 0);
        chk({p, "_mem_addr"}, bus.mem_addr, 0);
        chk({p, "_din"},      bus.proc_din, 0);
        chk({p, "_run"},      bus.proc_run, 0);
        chk({p, "_busy"},     bus.busy, 0);
        chk({p, "_halted"},   bus.halted, 0);
        chk({p, "_error"},    bus.error, 0);
    endtask

    initial begin
        int c, addr, n;
        logic [2:0] rop;
        rst = 1'b1; bus.start = 1'b0; bus.stop = 1'b0; bus.proc_done = 1'b0;
        hold = 0; chk_en = 0; pend = 0; k = 0; tgt = 1; runs = 0; ii = 0; op = 3'd0;

        clear_mem();
        do_reset();
        chk_reset_vals("rst");

        bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        chk("idle_start_stop_busy", bus.busy, 0);

        // MVI R0,#5 then HALT
        clear_mem();
        mem[0] = 9'b001_000_000; mem[1] = 9'h005; mem[2] = W_HALT;
        do_reset();
        exp_ins[0] = mem[0]; exp_pc[0] = 6'd0; exp_imm[0] = 9'h005;
        chk_en = 1;
        pulse_start();
        for (c = 0; c < 60 && !bus.halted; c++) tick();
        chk_en = 0;
        chk("mvi_halted", bus.halted, 1);
        chk("mvi_pc", bus.pc, 2);
        chk("mvi_count", bus.instr_count, 1);
        chk("mvi_runs", runs, 1);
        chk("mvi_busy", bus.busy, 0);

        // ADD retires on the third WAIT cycle
        clear_mem();
        mem[0] = W_ADD;
        do_reset();
        pulse_start();
        for (c = 0; c < 20 && !(pend != 0 && k == 2); c++) tick();
        chk("add_reach_wait2", (pend != 0 && k == 2), 1);
        chk("add_wait2_count", bus.instr_count, 0);
        tick();
        chk("add_wait3_pc", bus.pc, 0);
        tick();
        chk("add_ret_pc", bus.pc, 1);
        chk("add_ret_count", bus.instr_count, 1);
        chk("add_fetch_busy", bus.busy, 1);
        chk("add_fetch_addr", bus.mem_addr, 1);
        chk("add_fetch_run", bus.proc_run, 0);

        // Done never arrives
        clear_mem();
        mem[0] = W_ADD;
        do_reset();
        hold = 1;
        pulse_start();
        for (c = 0; c < 40 && !(pend != 0 && k == 15); c++) tick();
        chk("to_reach_wait15", (pend != 0 && k == 15), 1);
        chk("to_wait15_error", bus.error, 0);
        chk("to_wait15_busy", bus.busy, 1);
        tick();
        chk("to_error", bus.error, 1);
        chk("to_busy", bus.busy, 0);
        chk("to_run", bus.proc_run, 0);
        chk("to_pc", bus.pc, 0);
        repeat (3) tick();
        chk("to_sticky", bus.error, 1);
        hold = 0;

        // Stop during the ISSUE of the MV at PC=4
        clear_mem();
        for (int i = 0; i < 6; i++) mem[i] = 9'b000_000_001 + 9'(i);
        do_reset();
        pulse_start();
        for (c = 0; c < 60 && !(bus.proc_run && runs == 5); c++) tick();
        chk("stop_reach_issue4", (bus.proc_run && runs == 5), 1);
        chk("stop_issue_addr", bus.mem_addr, 5);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        for (c = 0; c < 20 && bus.busy; c++) tick();
        chk("stop_busy", bus.busy, 0);
        chk("stop_pc", bus.pc, 5);
        chk("stop_count", bus.instr_count, 5);
        repeat (3) tick();
        chk("stop_idle_pc", bus.pc, 5);
        pulse_start();
        chk("resume_busy", bus.busy, 1);
        chk("resume_addr", bus.mem_addr, 5);
        for (c = 0; c < 40 && !bus.halted; c++) tick();
        chk("resume_pc", bus.pc, 6);
        chk("resume_count", bus.instr_count, 6);

        // MVI at the last address takes its immediate from address 0
        clear_mem();
        for (int i = 0; i < 63; i++) mem[i] = 9'b000_010_011;
        mem[63] = 9'b001_000_000;
        do_reset();
        pulse_start();
        for (c = 0; c < 400 && !(bus.proc_run && runs == 64); c++) tick();
        chk("wrap_reach_issue63", (bus.proc_run && runs == 64), 1);
        chk("wrap_issue_addr", bus.mem_addr, 0);
        chk("wrap_issue_din", bus.proc_din, 9'h040);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("wrap_imm_din", bus.proc_din, 9'h013);
        for (c = 0; c < 20 && bus.busy; c++) tick();
        chk("wrap_pc", bus.pc, 1);
        chk("wrap_count", bus.instr_count, 64);

        // Retired-instruction counter wraps at 256
        clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 9'b000_011_100;
        do_reset();
        pulse_start();
        for (c = 0; c < 1200 && !(bus.proc_run && runs == 257); c++) tick();
        chk("cnt_reach_257", (bus.proc_run && runs == 257), 1);
        chk("cnt_wrap", bus.instr_count, 0);
        chk("cnt_pc", bus.pc, 0);

        // Reset in WAIT of an ADD, with every other input asserted
        clear_mem();
        mem[0] = W_ADD;
        do_reset();
        pulse_start();
        for (c = 0; c < 20 && !(pend != 0 && k == 2); c++) tick();
        chk("mid_reach_wait2", (pend != 0 && k == 2), 1);
        rst = 1'b1; bus.start = 1'b1; bus.stop = 1'b1; bus.proc_done = 1'b1;
        tick();
        chk_reset_vals("mid");
        rst = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
        tick();
        chk("mid_after_busy", bus.busy, 0);
        chk("mid_after_count", bus.instr_count, 0);

        // Random programs: the model walks the word list it generated
        for (int t = 0; t < 4; t++) begin
            clear_mem();
            addr = 0;
            n = $urandom_range(5, 15);
            for (int i = 0; i < n; i++) begin
                rop = 3'($urandom_range(0, 6));
                mem[addr] = {rop, 6'($urandom)};
                exp_ins[i] = mem[addr];
                exp_pc[i] = 6'(addr);
                if (rop == 3'b001) begin
                    mem[addr+1] = 9'($urandom);
                    exp_imm[i] = mem[addr+1];
                    addr += 2;
                end else begin
                    addr += 1;
                end
            end
            mem[addr] = {3'b111, 6'($urandom)};
            do_reset();
            chk_en = 1;
            pulse_start();
            for (c = 0; c < 600 && !bus.halted && !bus.error; c++) begin
                bus.start = ($urandom_range(0, 3) == 0);
                tick();
            end
            bus.start = 1'b0;
            chk_en = 0;
            chk("rnd_halted", bus.halted, 1);
            chk("rnd_error", bus.error, 0);
            chk("rnd_pc", bus.pc, addr);
            chk("rnd_count", bus.instr_count, n);
            chk("rnd_runs", runs, n);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
